// File: rtl/floating_divide_if.sv
// ---------------------------------------------------------------------------
// floating_divide_if
// Handshake and data bundle for the sequential floating-point divider.
//   start    : request, sampled by the divider only while it is idle
//   a, b     : dividend / divisor words, sampled together with start
//   busy     : high from start acceptance until done
//   done     : one-cycle pulse, out / div_zero / debug valid
//   out      : quotient word, held until the next done
//   div_zero : divisor was zero, held with out
//   debug    : sign-extended biased result exponent before clamping
// master drives the request side; slave is the divider.
// ---------------------------------------------------------------------------
interface floating_divide_if #(
    parameter int W = 32
);
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  out;
    logic          div_zero;
    logic [31:0]   debug;

    modport master (
        output start, a, b,
        input  busy, done, out, div_zero, debug
    );

    modport slave (
        input  start, a, b,
        output busy, done, out, div_zero, debug
    );
endinterface

// File: rtl/floating_divide.sv
// ---------------------------------------------------------------------------
// floating_divide
// Sequential floating-point divider, out = a / b. Restoring division with one
// quotient bit per clock; truncation, no rounding; a zero exponent field is
// treated as the value zero (no denormals).
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, aborts any division in flight
//   bus   : floating_divide_if.slave (start/a/b in, busy/done/out/div_zero/
//           debug out)
//
// Optional feature macro: FLOATING_DIVIDE_SPECIALS_EN
//   defined   : exponent field all-ones is honoured (NaN / infinity rules)
//   undefined : all-ones is an ordinary exponent, 0/0 follows the b-zero rule
// ---------------------------------------------------------------------------
module floating_divide #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic            clk,
    input  logic            rst_n,
    floating_divide_if.slave bus
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int M  = MANT_W + 1;      // mantissa including hidden one
    localparam int QW = M + 1;           // quotient bits, one per iteration
    localparam int RW = M + 2;           // remainder keeps a guard bit for the shift
    localparam int EW = EXP_W + 2;       // signed exponent with overflow headroom
    localparam int CW = $clog2(QW + 1);

    localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);
    localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);
    localparam logic signed [EW-1:0] EXP_SAT   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_BIAS  = EW'(BIAS);
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_PACK
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [W-1:0]           out_q;
    logic                   div_zero_q;
    logic [31:0]            debug_q;

    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [RW-1:0]          rem_q;
    logic [M-1:0]           bm_q;
    logic [QW-1:0]          q_q;
    logic [CW-1:0]          cnt_q;
    logic                   spec_q;
    logic                   spec_dz_q;
    logic [W-1:0]           spec_res_q;

    // ---------------------------------------------------------------------
    // Operand decode and special-case resolution at start acceptance
    // ---------------------------------------------------------------------
    logic                   res_sign;
    logic [EXP_W-1:0]       a_exp;
    logic [EXP_W-1:0]       b_exp;
    logic [MANT_W-1:0]      a_frac;
    logic [MANT_W-1:0]      b_frac;
    logic                   a_zero;
    logic                   b_zero;
    logic signed [EW-1:0]   exp_start_d;
    logic                   spec_d;
    logic                   spec_dz_d;
    logic [W-1:0]           spec_res_d;
    logic [W-1:0]           inf_res;
    logic [W-1:0]           zero_res;

`ifdef FLOATING_DIVIDE_SPECIALS_EN
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
    logic a_max;
    logic b_max;
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;
`endif

    // NOTE: every signal of an always_comb block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        res_sign    = bus.a[W-1] ^ bus.b[W-1];
        a_exp       = bus.a[W-2 -: EXP_W];
        b_exp       = bus.b[W-2 -: EXP_W];
        a_frac      = bus.a[MANT_W-1:0];
        b_frac      = bus.b[MANT_W-1:0];
        a_zero      = (a_exp == '0);
        b_zero      = (b_exp == '0);
        exp_start_d = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + EXP_BIAS;
        inf_res     = {res_sign, EXP_ONES, {MANT_W{1'b0}}};
        zero_res    = {res_sign, {(W-1){1'b0}}};
        spec_d      = 1'b0;
        spec_dz_d   = 1'b0;
        spec_res_d  = '0;
`ifdef FLOATING_DIVIDE_SPECIALS_EN
        a_max = (a_exp == EXP_ONES);
        b_max = (b_exp == EXP_ONES);
        a_nan = a_max && (a_frac != '0);
        b_nan = b_max && (b_frac != '0);
        a_inf = a_max && (a_frac == '0);
        b_inf = b_max && (b_frac == '0);
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_d     = 1'b1;
            spec_res_d = QNAN;
            spec_dz_d  = a_zero && b_zero;
        end else if (a_inf) begin
            spec_d     = 1'b1;
            spec_res_d = inf_res;
        end else if (b_inf) begin
            spec_d     = 1'b1;
            spec_res_d = zero_res;
        end else if (b_zero) begin
            spec_d     = 1'b1;
            spec_res_d = inf_res;
            spec_dz_d  = 1'b1;
        end else if (a_zero) begin
            spec_d     = 1'b1;
            spec_res_d = zero_res;
        end
`else
        if (b_zero) begin
            spec_d     = 1'b1;
            spec_res_d = inf_res;
            spec_dz_d  = 1'b1;
        end else if (a_zero) begin
            spec_d     = 1'b1;
            spec_res_d = zero_res;
        end
`endif
    end

    // ---------------------------------------------------------------------
    // One restoring-division step: subtract when the remainder covers the
    // divisor, shift the remainder left, append the quotient bit.
    // ---------------------------------------------------------------------
    logic            ge_d;
    logic [RW-1:0]   rem_sub_d;
    logic [RW-1:0]   rem_d;
    logic [QW-1:0]   q_d;

    always_comb begin
        ge_d      = (rem_q >= {2'b00, bm_q});
        rem_sub_d = ge_d ? (rem_q - {2'b00, bm_q}) : rem_q;
        rem_d     = rem_sub_d << 1;
        q_d       = {q_q[QW-2:0], ge_d};
    end

    // ---------------------------------------------------------------------
    // Normalise and pack. The quotient of two [1,2) mantissas lies in
    // (0.5, 2): either the top bit is set, or the next one is and the
    // exponent drops by one.
    // ---------------------------------------------------------------------
    logic [MANT_W-1:0]     mant_d;
    logic signed [EW-1:0]  exp_pack_d;
    logic [W-1:0]          pack_res_d;
    logic [31:0]           debug_d;

    always_comb begin
        if (q_q[QW-1]) begin
            mant_d     = q_q[QW-2:1];
            exp_pack_d = exp_q;
        end else begin
            mant_d     = q_q[QW-3:0];
            exp_pack_d = exp_q - EXP_ONE;
        end

        if (exp_pack_d >= EXP_SAT) begin
            pack_res_d = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
        end else if (exp_pack_d <= EXP_ZERO) begin
            pack_res_d = {sign_q, {(W-1){1'b0}}};
        end else begin
            pack_res_d = {sign_q, exp_pack_d[EXP_W-1:0], mant_d};
        end

        // Specials skip the divide, so report the unadjusted exponent.
        if (spec_q) begin
            debug_d = {{(32-EW){exp_q[EW-1]}}, exp_q};
        end else begin
            debug_d = {{(32-EW){exp_pack_d[EW-1]}}, exp_pack_d};
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
            div_zero_q <= 1'b0;
            debug_q    <= '0;
            // NOTE: the datapath registers are reset as well; they are
            // plain flops, not memory, and a known value keeps an aborted
            // division from leaking into debug visibility.
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            bm_q       <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_dz_q  <= 1'b0;
            spec_res_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        sign_q     <= res_sign;
                        exp_q      <= exp_start_d;
                        rem_q      <= RW'({1'b1, a_frac});
                        bm_q       <= {1'b1, b_frac};
                        q_q        <= '0;
                        cnt_q      <= '0;
                        spec_q     <= spec_d;
                        spec_dz_q  <= spec_dz_d;
                        spec_res_q <= spec_res_d;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        state_q    <= spec_d ? S_PACK : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_PACK;
                    end
                end
                S_PACK: begin
                    out_q      <= spec_q ? spec_res_q : pack_res_d;
                    div_zero_q <= spec_q & spec_dz_q;
                    debug_q    <= debug_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.div_zero = div_zero_q;
    assign bus.debug    = debug_q;

endmodule

// File: doc/floating_divide.md
Name: floating_divide

Overview:
- Sequential floating-point divider producing out = a / b; the inverse-operation companion to the team's single-cycle floating multiplier in the Phaethon arithmetic unit.
- Same simplified format rules as the multiplier: truncation (no rounding), no denormals (zero exponent field = zero value).
- Restoring division, one quotient bit per clock, with a start/busy/done handshake so the core sequencer can stall on it.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored mantissa width; hidden 1 implied.
- BIAS, 127, exponent bias.
- Word width W = 1+EXP_W+MANT_W (32 at defaults). All values below assume defaults.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  dividend; sampled with start.
- b  input  W  divisor; sampled with start.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse; out valid.
- out  output  W  result; held until next done.
- div_zero  output  1  set with done when b is zero; held with out.
- debug  output  32  sign-extended biased result exponent before clamping; updated with out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, out, div_zero, debug = 0; counter and datapath registers = 0. Reset mid-division aborts with no done.
- States: IDLE, DIVIDE, PACK.
- IDLE + start at edge E0:
  - latch sign = a[31]^b[31]
  - latch exp = aExp - bExp + BIAS in a signed 10-bit register
  - latch 24-bit mantissas {1,frac}
  - busy=1, counter=0, next state = DIVIDE.
- Special cases at E0 go straight to PACK, so done appears at E1:
  - b exp field 0: result {sign, 0xFF, 0}, div_zero=1.
  - else a exp field 0: result {sign, 0, 0}.
- DIVIDE, edges E1..E25 (25 iterations), per edge:
  - ge = (rem >= bM)
  - q = {q[23:0], ge}
  - rem = (ge ? rem-bM : rem) << 1
  - Initial rem = aM (26-bit register).
  - At counter==24 the next state is PACK.
- PACK at E26:
  - if q[24]=1: mant=q[23:1], exp unchanged; else mant=q[22:0], exp=exp-1.
  - exp >= 255: {sign, 0xFF, 0}. exp <= 0: {sign, 0, 0} (flush).
  - Register out and debug; done=1, busy=0, state=IDLE.
- Latency: normal ops have done high in the cycle after E26; special cases in the cycle after E1.
- Handshake:
  - start while busy (including the PACK edge) is ignored.
  - start on the cycle done is high is accepted, giving back-to-back operation.
  - done is low on every edge except the PACK edge.
- div_zero is cleared when the next start is accepted.

Optional Feature:
- FLOATING_DIVIDE_SPECIALS_EN defined: exp field 0xFF operands are honoured.
  - Any NaN operand, inf/inf, or 0/0 gives 0x7FC00000.
  - inf/finite gives signed infinity.
  - finite/inf gives signed zero.
  - All of these resolve via the E0 special path.
  - 0/0 sets div_zero=1.
- Not defined: exp 0xFF is treated as an ordinary exponent; 0/0 follows the b-zero rule (signed infinity, div_zero=1).

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start -> done in cycle after E26, out=0x40400000, div_zero=0, busy high E0..E26.
- a=0x3F800000, b=0x40400000 (1/3) -> out=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- a=0xBFC00000 (-1.5), b=0x3F000000 (0.5) -> out=0xC0400000 (-3.0). Re-issue start on the done cycle with 1.0/1.0 -> next out=0x3F800000.
- a=0x40000000, b=0x00000000 -> done at E1, out=0x7F800000, div_zero=1. A second start during busy of a normal op is ignored (single done).
- a=0x7F000000, b=0x00800000 -> out=0x7F800000 (overflow), div_zero=0. a=0x00800000, b=0x7F000000 -> out=0x00000000 (underflow flush).
- Reset: rst_n=0 at counter=10 -> busy/done/out=0 immediately, no done afterwards. Then 1.0/1.0 -> out=0x3F800000. With SPECIALS_EN: 0x7FC00000/0x3F800000 -> 0x7FC00000.
